adder_nibble_sequencer: RTL
===========================

# adder_nibble_sequencer

Multi-cycle controller that sequences a single 4-bit Kogge-Stone adder slice to add wide operands. Operands arrive one nibble pair per handshake, least-significant nibble first. After the last pair is accepted, the block runs the slice once per nibble, chaining the carry through a register, then holds the full-width result until the consumer accepts it. It sits between the 8-bit `ui_in` pin bus (a nibble in `[3:0]`, b nibble in `[7:4]`) and the output pins, replacing the single-shot 4-bit add with an N-nibble word add.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; legal range 2–8; result width is 4·NIBBLES.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: nibble pair present on `in_a`/`in_b`.
- `in_ready` out 1: block accepts a pair this cycle.
- `in_a` in 4: operand A nibble.
- `in_b` in 4: operand B nibble.
- `in_op` in 1: 0 = add, 1 = subtract; sampled only with beat 0; see Configuration.
- `out_valid` out 1: result held on `out_sum`/`out_cout`.
- `out_ready` in 1: consumer accepts result.
- `out_sum` out 4·NIBBLES: result word.
- `out_cout` out 1: final carry (in subtract mode, 1 = no borrow).
- `busy` out 1: high in ADD and DONE.

## Operation
- States:
  - LOAD: `in_ready`=1.
  - ADD: `in_ready`=0.
  - DONE: `out_valid`=1.
- Nibble counter `cnt` runs 0..NIBBLES-1.
- LOAD:
  - Each accept (`in_valid`&&`in_ready`) writes `in_a`/`in_b` into operand registers at nibble `cnt`, then increments `cnt`.
  - Beat 0 also latches `in_op`.
  - The accept with `cnt`==NIBBLES-1 moves to ADD and clears `cnt`.
- ADD, one cycle per nibble:
  - The slice computes A[cnt] + B'[cnt] + carry_reg.
  - The 4-bit sum is written to `out_sum` nibble `cnt`; the slice carry-out goes to carry_reg.
  - carry_reg is loaded at ADD entry with 0 (add) or 1 (subtract).
  - B' = B (add) or ~B (subtract).
  - After nibble NIBBLES-1, carry_reg is copied to `out_cout` and the state moves to DONE.
- Slice:
  - p=a^b, g=a&b.
  - Two-level Kogge-Stone prefix including carry-in as g[-1].
  - sum=p^{c}.
  - Arithmetic is modulo 2^(4·NIBBLES); no overflow flag.
- DONE:
  - `out_sum`/`out_cout` remain stable while `out_valid`=1 and `out_ready`=0.
  - On `out_valid`&&`out_ready`: go to LOAD, `cnt`=0. `out_sum`/`out_cout` keep their last value until overwritten by the next ADD.
- `in_valid` during ADD/DONE is ignored; no pair is consumed.
- Reset, any time including mid-LOAD/ADD:
  - State LOAD, `cnt`=0, operands and carry_reg cleared.
  - Outputs reset to `in_ready`=1, `out_valid`=0, `busy`=0, `out_sum`=0, `out_cout`=0.
  - Partially loaded pairs are discarded.

## Timing
- All outputs are registered or decoded from state; no combinational path from inputs to outputs.
- Load: NIBBLES accept cycles minimum, back-to-back allowed; `in_valid` gaps stall loading indefinitely.
- Last accept at edge T:
  - State=ADD from T.
  - Nibble k computed at edge T+1+k.
  - `out_valid`=1 and `busy`=1 from edge T+NIBBLES.
  - Add latency = NIBBLES cycles after the last accept.
- Result handshake at edge R: `in_ready`=1 and `busy`=0 from R. A new beat 0 can be accepted at edge R+1.
- Throughput with continuous `out_ready`: one result per 2·NIBBLES+1 cycles.

## Configuration
- `ADDSEQ_SUB_EN` defined:
  - Subtract mode enabled; `in_op`=1 gives A−B (two's complement: ~B, carry-in 1).
  - `out_cout`=1 iff A≥B unsigned.
- `ADDSEQ_SUB_EN` undefined:
  - `in_op` is ignored; op register and B inversion are not built.
  - Carry-in is always 0; add only.

## Test plan
- Add, NIBBLES=4: pairs (4,1),(3,2),(2,3),(1,4), i.e. A=0x1234, B=0x4321 → `out_sum`=0x5555, `out_cout`=0, `out_valid` exactly 4 cycles after the last accept.
- Full carry ripple: A=0xFFFF, B=0x0001 → `out_sum`=0x0000, `out_cout`=1; also A=B=0xFFFF → 0xFFFE, `out_cout`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_sum`/`out_cout` stable, `in_ready`=0, beats offered with `in_valid`=1 are not consumed; raise `out_ready` → LOAD next cycle.
- Reset mid-ADD: assert `rst_n`=0 two cycles into ADD → all outputs at reset values immediately; after release, a fresh 0x0001+0x0002 yields 0x0003.
- Load stalls: `in_valid` toggled 1/0 across 4 beats → result equals the no-gap result; `cnt` advances only on accepts.
- With `ADDSEQ_SUB_EN`:
  - A=0x0005, B=0x0007, `in_op`=1 → 0xFFFE, `out_cout`=0.
  - A=0x0007, B=0x0005 → 0x0002, `out_cout`=1.
  - Without the macro, the same stimulus yields 0x000C, `out_cout`=0.

Source files
------------

// File: rtl/adder_nibble_sequencer.sv
// adder_nibble_sequencer
// Sequences one 4-bit Kogge-Stone slice over NIBBLES nibble pairs to form a
// 4*NIBBLES-bit add. Operands are loaded LS nibble first, one pair per
// in_valid/in_ready handshake. The slice then runs once per nibble with the
// carry chained through r_carry. The result is held until out_ready.
// Optional feature macro: ADDSEQ_SUB_EN (enables in_op = 1 subtract, A - B).
module adder_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_a,
  input  logic [3:0]             in_b,
  input  logic                   in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout,
  output logic                   busy
);

  localparam int CW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;

  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_a   [NIBBLES];
  logic [3:0]    r_b   [NIBBLES];
  logic [3:0]    r_sum [NIBBLES];
  logic          r_carry;
  logic          r_cout;

  logic          w_accept;
  logic          w_cnt_last;
  logic          w_carry_init;
  logic [3:0]    w_slice_a;
  logic [3:0]    w_slice_b;
  logic [3:0]    w_slice_sum;
  logic          w_slice_cout;

`ifdef ADDSEQ_SUB_EN
  logic          r_op;

  // Capture the operation with beat 0; it governs B inversion and carry-in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= 1'b0;
    end else if (w_accept && (r_cnt == CNT_ZERO)) begin
      r_op <= in_op;
    end
  end

  // Two's-complement subtract: invert B and start the chain with carry 1.
  // The last beat is never beat 0 (NIBBLES >= 2), so r_op is already valid.
  always_comb begin
    w_slice_b    = r_b[r_cnt] ^ {4{r_op}};
    w_carry_init = r_op;
  end
`else
  logic          w_unused_op;

  assign w_unused_op = in_op;

  // Add-only build: B passes straight through and the chain starts at 0.
  always_comb begin
    w_slice_b    = r_b[r_cnt];
    w_carry_init = 1'b0;
  end
`endif

  assign w_accept   = in_valid && (r_state == ST_LOAD);
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_slice_a  = r_a[r_cnt];

  // 4-bit Kogge-Stone slice; carry-in enters the prefix tree as g[-1].
  // Index j of the level arrays is bit j-1, so j = 0 holds the carry-in.
  always_comb begin
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_g0;
    logic [4:0] w_p0;
    logic [4:0] w_g1;
    logic [4:0] w_p1;
    logic [4:0] w_g2;
    logic [3:0] w_c;

    w_p = w_slice_a ^ w_slice_b;
    w_g = w_slice_a & w_slice_b;

    w_g0 = {w_g, r_carry};
    w_p0 = {w_p, 1'b0};

    // Level 1: span 2.
    w_g1[0] = w_g0[0];
    w_p1[0] = w_p0[0];
    for (int unsigned j = 1; j < 5; j++) begin
      w_g1[j] = w_g0[j] | (w_p0[j] & w_g0[j-1]);
      w_p1[j] = w_p0[j] & w_p0[j-1];
    end

    // Level 2: span 4, enough for every carry into bits 0..3.
    w_g2[0] = w_g1[0];
    w_g2[1] = w_g1[1];
    for (int unsigned j = 2; j < 5; j++) begin
      w_g2[j] = w_g1[j] | (w_p1[j] & w_g1[j-2]);
    end

    // Carry into bit i is the group generate from carry-in up to bit i-1.
    w_c          = w_g2[3:0];
    w_slice_sum  = w_p ^ w_c;
    // Carry-out of bit 3 closes the chain from the bit-3 prefix.
    w_slice_cout = w_g[3] | (w_p[3] & w_c[3]);
  end

  // Control FSM: LOAD collects pairs, ADD walks the nibbles, DONE holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
      r_cnt   <= CNT_ZERO;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            if (w_cnt_last) begin
              r_cnt   <= CNT_ZERO;
              r_state <= ST_ADD;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        ST_ADD: begin
          if (w_cnt_last) begin
            r_cnt   <= CNT_ZERO;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_cnt   <= CNT_ZERO;
            r_state <= ST_LOAD;
          end
        end
        default: begin
          r_cnt   <= CNT_ZERO;
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  // Operand storage: each accepted pair lands at nibble position r_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NIBBLES; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else if (w_accept) begin
      r_a[r_cnt] <= in_a;
      r_b[r_cnt] <= in_b;
    end
  end

  // Carry chain: seeded on ADD entry, then takes each slice carry-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
    end else if (w_accept && w_cnt_last) begin
      r_carry <= w_carry_init;
    end else if (r_state == ST_ADD) begin
      r_carry <= w_slice_cout;
    end
  end

  // Result registers: written one nibble per ADD cycle, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NIBBLES; i++) begin
        r_sum[i] <= '0;
      end
      r_cout <= 1'b0;
    end else if (r_state == ST_ADD) begin
      r_sum[r_cnt] <= w_slice_sum;
      if (w_cnt_last) begin
        r_cout <= w_slice_cout;
      end
    end
  end

  // Output decode: handshakes come from state, data from result registers.
  always_comb begin
    out_sum = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      out_sum[i*4 +: 4] = r_sum[i];
    end
    out_cout  = r_cout;
    in_ready  = (r_state == ST_LOAD);
    out_valid = (r_state == ST_DONE);
    busy      = (r_state != ST_LOAD);
  end

endmodule
